// File: rtl/sid_pkg.sv
// Shared definitions for the SID envelope VCA: default sample width, FSM states and smoothing step.
package sid_pkg;
  localparam int         SAMPLE_W_DEF = 12;
  localparam int         ENV_W        = 8;
  localparam logic [7:0] SMOOTH_STEP  = 8'd16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    OUT  = 2'd2
  } vca_state_t;

  // Slew-limited move of cur toward tgt; lands exactly on tgt when within one step.
  function automatic logic [7:0] smooth_toward(input logic [7:0] cur, input logic [7:0] tgt);
    logic [7:0] diff;
    if (tgt > cur) begin
      diff = tgt - cur;
      return (diff > SMOOTH_STEP) ? cur + SMOOTH_STEP : tgt;
    end else begin
      diff = cur - tgt;
      return (diff > SMOOTH_STEP) ? cur - SMOOTH_STEP : tgt;
    end
  endfunction
endpackage

// File: rtl/sid_serial_mult.sv
// Bit-serial shift-add multiplier: signed sample x unsigned 8-bit envelope, one envelope bit per step, LSB first.
module sid_serial_mult
  import sid_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic                i_step,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic [ENV_W-1:0]    i_env,
  output logic                o_last,
  output logic [SAMPLE_W-1:0] o_result
);
  localparam int ACC_W = SAMPLE_W + ENV_W;

  logic [SAMPLE_W-1:0]     r_sample;
  logic [ENV_W-1:0]        r_env;
  logic signed [ACC_W-1:0] r_acc;
  logic [2:0]              r_idx;
  logic signed [ACC_W-1:0] w_addend;
  logic signed [ACC_W-1:0] w_acc_next;

  always_comb begin
    w_addend   = $signed({{ENV_W{r_sample[SAMPLE_W-1]}}, r_sample}) <<< r_idx;
    w_acc_next = r_env[r_idx] ? r_acc + w_addend : r_acc;
  end

  assign o_last = (r_idx == 3'd7);
  // Full scale (0xFF) would give s*255/256, so it bypasses to unity gain; else acc >>> 8 truncated.
  assign o_result = (r_env == 8'hFF) ? r_sample : w_acc_next[ENV_W +: SAMPLE_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample <= '0;
      r_env    <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
    end else if (i_load) begin
      r_sample <= i_sample;
      r_env    <= i_env;
      r_acc    <= '0;
      r_idx    <= '0;
    end else if (i_step) begin
      r_acc    <= w_acc_next;
      r_idx    <= r_idx + 3'd1;
    end
  end
endmodule

// File: rtl/sid_envelope_vca.sv
// SID-style VCA: scales a waveform sample by the ADSR envelope level with a serial multiplier.
// Optional envelope slew limiting when SID_VCA_SMOOTH_EN is defined.
module sid_envelope_vca
  import sid_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_sample,
  input  logic [ENV_W-1:0]    env_value,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_sample
);
  vca_state_t          r_state;
  vca_state_t          w_state_nxt;
  logic                w_accept;
  logic                w_last;
  logic [ENV_W-1:0]    w_env_eff;
  logic [SAMPLE_W-1:0] w_prod;
  logic [SAMPLE_W-1:0] r_out_sample;

  assign w_accept = in_valid && (r_state == IDLE);

`ifdef SID_VCA_SMOOTH_EN
  logic [ENV_W-1:0] r_env_eff;
  assign w_env_eff = smooth_toward(r_env_eff, env_value);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_env_eff <= '0;
    else if (w_accept) r_env_eff <= w_env_eff;
  end
`else
  assign w_env_eff = env_value;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = MUL;
      MUL:     if (w_last)    w_state_nxt = OUT;
      OUT:     if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_out_sample <= '0;
    else if ((r_state == MUL) && w_last) r_out_sample <= w_prod;
  end

  assign out_sample = r_out_sample;

  sid_serial_mult #(.SAMPLE_W(SAMPLE_W)) u_mult (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_accept),
    .i_step   (r_state == MUL),
    .i_sample (in_sample),
    .i_env    (w_env_eff),
    .o_last   (w_last),
    .o_result (w_prod)
  );
endmodule

// File: doc/sid_envelope_vca.md
SID_ENVELOPE_VCA -- requirements
Module: sid_envelope_vca

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 12, width of the signed waveform sample.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; it is asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, upstream sample valid.
REQ-005 SHALL have port in_ready, output, 1, block can accept a sample.
REQ-006 SHALL have port in_sample, input, SAMPLE_W, two's-complement waveform sample.
REQ-007 SHALL have port env_value, input, 8, unsigned envelope level from the ADSR generator.
REQ-008 SHALL have port out_valid, output, 1, scaled sample valid.
REQ-009 SHALL have port out_ready, input, 1, downstream can accept.
REQ-010 SHALL have port out_sample, output, SAMPLE_W, two's-complement scaled sample.

Function
REQ-011 SHALL have FSM states IDLE, MUL and OUT; in_ready=1 only in IDLE; out_valid=1 only in OUT.
REQ-012 SHALL accept on the edge where in_valid&&in_ready (edge E), latching in_sample and env_eff, clearing the accumulator and entering MUL.
REQ-013 SHALL, in MUL, process one env_eff bit per edge, LSB first, on edges E+1..E+8: acc += (sign-extended sample << i) when bit i=1; acc is SAMPLE_W+8 bits signed.
REQ-014 SHALL, on edge E+8, register out_sample and enter OUT; out_valid is high from E+8 until handshake.
REQ-015 SHALL set out_sample = acc >>> 8 (arithmetic shift, truncation toward minus infinity).
REQ-016 SHALL pass out_sample = latched sample exactly when env_eff==8'hFF (unity bypass).
REQ-017 SHALL give out_sample = 0 when env_eff==8'h00.
REQ-018 SHALL hold out_sample stable while out_valid=1 and out_ready=0, with no limit on the stall length.
REQ-019 SHALL complete output on the edge where out_valid&&out_ready and return to IDLE; there is no same-cycle re-accept, so the minimum period is 10 cycles.
REQ-020 SHALL sample env_value only at edge E; changes to env_value during MUL or OUT SHALL be ignored.
REQ-021 SHALL ignore in_sample and in_valid outside IDLE.

Reset
REQ-022 SHALL, on rst assertion, immediately set state=IDLE, out_valid=0, out_sample=0, acc=0 and env_eff register=0, independent of clk.
REQ-023 SHALL discard any in-flight sample on reset mid-MUL or mid-OUT; after release, in_ready=1 with no output produced.

Configuration
REQ-024 SHALL, with SID_VCA_SMOOTH_EN defined, hold an env_eff register; at each acceptance it moves toward env_value by at most SMOOTH_STEP (16), without overshoot, and the updated value is used for that sample.
REQ-025 SHALL, without SID_VCA_SMOOTH_EN, set env_eff = env_value directly, with no smoothing register.

Structure
REQ-026 SHALL take the SAMPLE_W default, the state enum and SMOOTH_STEP from shared package sid_pkg.
REQ-027 SHALL place the shift-add datapath (acc, bit index, sample latch) in sub-module sid_serial_mult, with the FSM and handshake in sid_envelope_vca.

Verification
REQ-028 SHALL cover: in_sample=0x400, env=0x80 -> out_sample=0x200, out_valid rising 8 edges after acceptance.
REQ-029 SHALL cover: in_sample=0x800 (-2048), env=0xFF -> 0x800; in_sample=0x7FF, env=0x00 -> 0x000.
REQ-030 SHALL cover: in_sample=0xFFF (-1), env=0x01 -> 0xFFF (floor rounding).
REQ-031 SHALL cover: out_ready held low 5 cycles -> out_sample stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-032 SHALL cover: rst pulsed at edge E+4 -> out_valid never asserts, state IDLE; a next sample 0x400, env=0x80 -> 0x200.
REQ-033 SHALL cover, with SID_VCA_SMOOTH_EN: from reset, env=0xFF, sample 0x400 -> 0x040; the second sample uses env_eff=0x20 -> 0x080.
